xvec2_md_lane_seq: RTL and testbench
====================================

XVEC2_MD_LANE_SEQ -- requirements
Module: xvec2_md_lane_seq

Interface
REQ-001 The block SHALL have these parameters:
- XPR_LEN, 32, scalar lane width.
- LANES, 2, number of lanes; the vector width VEC_XPR_LEN equals LANES*XPR_LEN.

REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- vreq_valid  in  1  vector request valid.
- vreq_ready  out  1  sequencer can accept a vector request.
- vreq_in_1_signed  in  1  operand 1 is signed.
- vreq_in_2_signed  in  1  operand 2 is signed.
- vreq_op  in  MD_OP_WIDTH  MUL, DIV or REM.
- vreq_out_sel  in  MD_OUT_SEL_WIDTH  LO, HI or REM select.
- vreq_in_1  in  VEC_XPR_LEN  packed operand 1; lane k is bits [k*XPR_LEN +: XPR_LEN].
- vreq_in_2  in  VEC_XPR_LEN  packed operand 2.
- vresp_valid  out  1  vector result valid.
- vresp_ready  in  1  consumer accepts the result.
- vresp_result  out  VEC_XPR_LEN  packed per-lane results.
- md_req_valid  out  1  scalar mul/div request valid.
- md_req_ready  in  1  scalar unit ready.
- md_req_in_1_signed  out  1  latched operand-1 sign flag.
- md_req_in_2_signed  out  1  latched operand-2 sign flag.
- md_req_op  out  MD_OP_WIDTH  latched op.
- md_req_out_sel  out  MD_OUT_SEL_WIDTH  latched out_sel.
- md_req_in_1  out  XPR_LEN  current lane of operand 1.
- md_req_in_2  out  XPR_LEN  current lane of operand 2.
- md_resp_valid  in  1  scalar result valid.
- md_resp_result  in  XPR_LEN  scalar result.

Function
REQ-003 The block SHALL implement the states IDLE, ISSUE, WAIT and DONE, with a lane counter of clog2(LANES) bits.
REQ-004 In IDLE, vreq_ready SHALL be 1; when vreq_valid and vreq_ready are both 1, the block SHALL latch the operands, flags, op and out_sel, clear the result register, set lane to 0, and go to ISSUE.
REQ-005 In ISSUE, md_req_valid SHALL be 1 and the md_req_* outputs SHALL be driven from the latched registers for the current lane; the block SHALL go to WAIT on the cycle md_req_ready is 1, and stay in ISSUE otherwise.
REQ-006 In WAIT, when md_resp_valid is 1, the block SHALL write md_resp_result into lane slot [lane*XPR_LEN +: XPR_LEN]; it SHALL then go to DONE if lane is LANES-1, else increment lane and go to ISSUE.
REQ-007 md_resp_valid SHALL be ignored in every state except WAIT, including the handshake cycle in ISSUE.
REQ-008 In DONE, vresp_valid SHALL be 1 and vresp_result SHALL be held stable; the block SHALL go to IDLE on vresp_ready and stay in DONE otherwise.
REQ-009 vreq_ready SHALL be 0 outside IDLE; the block SHALL have no request overlap or pipelining.
REQ-010 With md_req_ready=1 and md_resp_valid=1 held constant, vresp_valid SHALL rise exactly 2*LANES+1 cycles after the vreq accept edge.
REQ-011 Lanes SHALL be processed in ascending order, and the lane counter SHALL never exceed LANES-1.
REQ-012 md_req_valid SHALL be 0 in IDLE, WAIT and DONE.

Reset
REQ-013 When reset is low, the block SHALL asynchronously force: state=IDLE, lane=0, result register=0, and all latched operand registers=0.
REQ-014 The reset output values SHALL be: vreq_ready=1, vresp_valid=0, md_req_valid=0, vresp_result=0.
REQ-015 A reset asserted mid-sequence SHALL abandon the sequence; a scalar response arriving after reset is released SHALL be ignored, per REQ-007.

Configuration
REQ-016 With XVEC2_MD_ZERO_SKIP_EN defined, when the latched op is MUL and the current lane of either operand is zero, the block SHALL write 0 into that lane slot directly from ISSUE without asserting md_req_valid, and advance as in REQ-006.
REQ-017 Without XVEC2_MD_ZERO_SKIP_EN, every lane SHALL be issued to the scalar unit.

Verification
REQ-018 The bench SHALL cover these directed scenarios, using LANES=2 and a model scalar unit with a 1-cycle response:
- Signed MUL, LO, in_1 lanes {3, 0xFFFFFFFE}, in_2 lanes {5, 7} -> vresp_result lanes {0x0000000F, 0xFFFFFFF2}, vresp_valid at accept+5.
- Unsigned DIV, in_1 lanes {100, 9}, in_2 lanes {7, 3} -> lanes {14, 3}.
- md_req_ready held low for 4 cycles in lane 0 -> md_req_valid stays 1, md_req_in_1 is stable, result is correct, latency is accept+9.
- vresp_ready low for 3 cycles in DONE -> vresp_valid and vresp_result are stable and vreq_ready=0; IDLE is reached the cycle after vresp_ready rises.
- reset pulsed low during WAIT of lane 1 -> outputs immediately take the REQ-014 values; a stray md_resp_valid after release changes nothing; the next request completes correctly.
- With XVEC2_MD_ZERO_SKIP_EN, MUL with in_1 lanes {0, 4}, in_2 lanes {9, 2} -> lane 0 is never issued, result lanes {0, 8}, latency accept+4.

Source files
------------

// File: rtl/xvec2_md_lane_seq.sv
// Sequences a LANES-wide vector mul/div request through one scalar mul/div unit, lane by lane.
// Optional XVEC2_MD_ZERO_SKIP_EN: MUL lanes with a zero operand are written as 0 without issuing.
module xvec2_md_lane_seq #(
  parameter int unsigned XPR_LEN          = 32,
  parameter int unsigned LANES            = 2,
  parameter int unsigned MD_OP_WIDTH      = 2,
  parameter int unsigned MD_OUT_SEL_WIDTH = 2,
  localparam int unsigned VEC_XPR_LEN     = LANES * XPR_LEN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        vreq_valid,
  output logic                        vreq_ready,
  input  logic                        vreq_in_1_signed,
  input  logic                        vreq_in_2_signed,
  input  logic [MD_OP_WIDTH-1:0]      vreq_op,
  input  logic [MD_OUT_SEL_WIDTH-1:0] vreq_out_sel,
  input  logic [VEC_XPR_LEN-1:0]      vreq_in_1,
  input  logic [VEC_XPR_LEN-1:0]      vreq_in_2,
  output logic                        vresp_valid,
  input  logic                        vresp_ready,
  output logic [VEC_XPR_LEN-1:0]      vresp_result,
  output logic                        md_req_valid,
  input  logic                        md_req_ready,
  output logic                        md_req_in_1_signed,
  output logic                        md_req_in_2_signed,
  output logic [MD_OP_WIDTH-1:0]      md_req_op,
  output logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
  output logic [XPR_LEN-1:0]          md_req_in_1,
  output logic [XPR_LEN-1:0]          md_req_in_2,
  input  logic                        md_resp_valid,
  input  logic [XPR_LEN-1:0]          md_resp_result
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                      state_q;
  logic [LANE_W-1:0]           lane_q;
  logic [VEC_XPR_LEN-1:0]      in_1_q, in_2_q, result_q, result_d;
  logic                        in_1_signed_q, in_2_signed_q;
  logic [MD_OP_WIDTH-1:0]      op_q;
  logic [MD_OUT_SEL_WIDTH-1:0] out_sel_q;

  logic [XPR_LEN-1:0] cur_in_1, cur_in_2, lane_data;
  logic               last_lane, skip_lane, lane_wr;

  always_comb begin
    cur_in_1 = '0;
    cur_in_2 = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane_q == LANE_W'(k)) begin
        cur_in_1 = in_1_q[k*XPR_LEN +: XPR_LEN];
        cur_in_2 = in_2_q[k*XPR_LEN +: XPR_LEN];
      end
    end
  end

`ifdef XVEC2_MD_ZERO_SKIP_EN
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = '0;
  assign skip_lane = (op_q == MD_OP_MUL) && ((cur_in_1 == '0) || (cur_in_2 == '0));
`else
  assign skip_lane = 1'b0;
`endif

  assign last_lane = (lane_q == LANE_W'(LANES - 1));
  assign lane_data = skip_lane ? '0 : md_resp_result;
  // A lane completes either from a scalar response in WAIT or a skipped MUL in ISSUE.
  assign lane_wr   = ((state_q == StIssue) && skip_lane) || ((state_q == StWait) && md_resp_valid);

  always_comb begin
    result_d = result_q;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane_q == LANE_W'(k)) result_d[k*XPR_LEN +: XPR_LEN] = lane_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      lane_q        <= '0;
      result_q      <= '0;
      in_1_q        <= '0;
      in_2_q        <= '0;
      in_1_signed_q <= 1'b0;
      in_2_signed_q <= 1'b0;
      op_q          <= '0;
      out_sel_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (vreq_valid) begin
            in_1_q        <= vreq_in_1;
            in_2_q        <= vreq_in_2;
            in_1_signed_q <= vreq_in_1_signed;
            in_2_signed_q <= vreq_in_2_signed;
            op_q          <= vreq_op;
            out_sel_q     <= vreq_out_sel;
            result_q      <= '0;
            lane_q        <= '0;
            state_q       <= StIssue;
          end
        end
        StIssue, StWait: begin
          if (lane_wr) begin
            result_q <= result_d;
            if (last_lane) begin
              state_q <= StDone;
            end else begin
              lane_q  <= lane_q + 1'b1;
              state_q <= StIssue;
            end
          end else if ((state_q == StIssue) && md_req_ready) begin
            state_q <= StWait;
          end
        end
        StDone: begin
          if (vresp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vreq_ready         = (state_q == StIdle);
  assign vresp_valid        = (state_q == StDone);
  assign vresp_result       = result_q;
  assign md_req_valid       = (state_q == StIssue) && !skip_lane;
  assign md_req_in_1_signed = in_1_signed_q;
  assign md_req_in_2_signed = in_2_signed_q;
  assign md_req_op          = op_q;
  assign md_req_out_sel     = out_sel_q;
  assign md_req_in_1        = cur_in_1;
  assign md_req_in_2        = cur_in_2;

endmodule

// File: tb/tb_xvec2_md_lane_seq.sv
// Scoreboard bench for xvec2_md_lane_seq: behavioural scalar unit, directed plus random vectors.
`timescale 1ns/1ps
module tb_xvec2_md_lane_seq;

  localparam int unsigned XPR = 32;
  localparam int unsigned NL  = 2;
  localparam int unsigned VW  = NL * XPR;
  localparam logic [1:0] OP_MUL = 2'd0, OP_DIV = 2'd1, OP_REM = 2'd2;
  localparam logic [1:0] SEL_LO = 2'd0, SEL_HI = 2'd1, SEL_REM = 2'd2;
`ifdef XVEC2_MD_ZERO_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic vreq_valid = 1'b0, vreq_ready, vreq_in_1_signed = 1'b0, vreq_in_2_signed = 1'b0;
  logic [1:0] vreq_op = '0, vreq_out_sel = '0;
  logic [VW-1:0] vreq_in_1 = '0, vreq_in_2 = '0, vresp_result;
  logic vresp_valid, vresp_ready = 1'b1;
  logic md_req_valid, md_req_ready = 1'b1, md_req_in_1_signed, md_req_in_2_signed;
  logic [1:0] md_req_op, md_req_out_sel;
  logic [XPR-1:0] md_req_in_1, md_req_in_2, md_resp_result = '0;
  logic md_resp_valid = 1'b0;

  xvec2_md_lane_seq #(.XPR_LEN(XPR), .LANES(NL), .MD_OP_WIDTH(2), .MD_OUT_SEL_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .vreq_valid(vreq_valid), .vreq_ready(vreq_ready),
    .vreq_in_1_signed(vreq_in_1_signed), .vreq_in_2_signed(vreq_in_2_signed),
    .vreq_op(vreq_op), .vreq_out_sel(vreq_out_sel),
    .vreq_in_1(vreq_in_1), .vreq_in_2(vreq_in_2),
    .vresp_valid(vresp_valid), .vresp_ready(vresp_ready), .vresp_result(vresp_result),
    .md_req_valid(md_req_valid), .md_req_ready(md_req_ready),
    .md_req_in_1_signed(md_req_in_1_signed), .md_req_in_2_signed(md_req_in_2_signed),
    .md_req_op(md_req_op), .md_req_out_sel(md_req_out_sel),
    .md_req_in_1(md_req_in_1), .md_req_in_2(md_req_in_2),
    .md_resp_valid(md_resp_valid), .md_resp_result(md_resp_result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct { logic [VW-1:0] res; int lat; } exp_t;
  typedef struct { logic [XPR-1:0] a; logic [XPR-1:0] b; } iss_t;
  exp_t sb_q[$];
  iss_t iss_q[$];

  int unsigned accept_cyc = 0;
  bit  seen_valid = 0, expect_idle = 0, stray = 0, pending = 0, stall_seen = 0;
  int  stall_cnt = 0, hold_cnt = 0, n_issue = 0, exp_iss = 0;
  logic [XPR-1:0] pend_res = '0, stall_a = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference scalar mul/div: operands extended per sign flag, full-width arithmetic.
  function automatic logic [XPR-1:0] scalar_fn(input logic [1:0] op, input logic [1:0] sel,
                                               input logic s1, input logic s2,
                                               input logic [XPR-1:0] a, input logic [XPR-1:0] b);
    longint x, y, r;
    x = s1 ? longint'($signed(a)) : longint'({32'd0, a});
    y = s2 ? longint'($signed(b)) : longint'({32'd0, b});
    case (op)
      OP_MUL: begin
        r = x * y;
        return (sel == SEL_HI) ? r[63:32] : r[31:0];
      end
      OP_DIV: begin
        if (y == 0) return '1;
        r = x / y;
        return r[31:0];
      end
      default: begin
        if (y == 0) return a;
        r = x % y;
        return r[31:0];
      end
    endcase
  endfunction

  function automatic logic [VW-1:0] vec_ref(input logic [1:0] op, input logic [1:0] sel,
                                            input logic s1, input logic s2,
                                            input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    for (int k = 0; k < NL; k++)
      r[k*XPR +: XPR] = scalar_fn(op, sel, s1, s2, a[k*XPR +: XPR], b[k*XPR +: XPR]);
    return r;
  endfunction

  // Scalar unit model: 1-cycle response after each handshake, optional ready stall.
  initial forever begin
    @(negedge clk);
    md_resp_valid = 1'b0;
    if (stray) begin
      md_resp_valid  = 1'b1;
      md_resp_result = 32'hDEADBEEF;
      stray = 0;
    end else if (pending) begin
      md_resp_valid  = 1'b1;
      md_resp_result = pend_res;
    end
    pending = 0;
    if (md_req_valid) begin
      if (stall_cnt > 0) begin
        if (stall_seen) chk("stall_in_1_stable", md_req_in_1, stall_a);
        stall_a = md_req_in_1;
        stall_seen = 1;
        md_req_ready = 1'b0;
        stall_cnt--;
      end else begin
        md_req_ready = 1'b1;
        stall_seen = 0;
        n_issue++;
        if (iss_q.size() == 0) begin
          chk("unexpected_issue", 64'd1, 64'd0);
        end else begin
          chk("issue_operands", {md_req_in_1, md_req_in_2}, {iss_q[0].a, iss_q[0].b});
          void'(iss_q.pop_front());
        end
        pend_res = scalar_fn(md_req_op, md_req_out_sel, md_req_in_1_signed,
                             md_req_in_2_signed, md_req_in_1, md_req_in_2);
        pending = 1;
      end
    end else begin
      md_req_ready = 1'b1;
    end
  end

  // Response monitor: drives vresp_ready backpressure and checks against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (expect_idle) begin
      chk("idle_after_pop", {vreq_ready, vresp_valid}, 2'b10);
      expect_idle = 0;
    end
    if (vresp_valid) begin
      if (hold_cnt > 0) begin
        vresp_ready = 1'b0;
        hold_cnt--;
      end else begin
        vresp_ready = 1'b1;
      end
      chk("vreq_ready_busy", vreq_ready, 1'b0);
      if (sb_q.size() == 0) begin
        chk("unexpected_vresp", 64'd1, 64'd0);
      end else begin
        chk("vresp_result", vresp_result, sb_q[0].res);
        if (!seen_valid) begin
          seen_valid = 1;
          // Latency counts clock edges from the accept edge to the first edge seeing valid.
          if (sb_q[0].lat >= 0) chk("latency", 64'(cyc + 1 - accept_cyc), 64'(sb_q[0].lat));
        end
        if (vresp_ready) begin
          void'(sb_q.pop_front());
          seen_valid = 0;
          expect_idle = 1;
        end
      end
    end else begin
      vresp_ready = 1'b1;
    end
  end

  task automatic send(input logic s1, input logic s2, input logic [1:0] op, input logic [1:0] sel,
                      input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic [VW-1:0] res, input int lat);
    exp_t e;
    iss_t it;
    @(negedge clk);
    chk("vreq_ready_idle", vreq_ready, 1'b1);
    e.res = res;
    e.lat = lat;
    sb_q.push_back(e);
    exp_iss = 0;
    n_issue = 0;
    for (int k = 0; k < NL; k++) begin
      it.a = a[k*XPR +: XPR];
      it.b = b[k*XPR +: XPR];
      if (!(SKIP_EN && op == OP_MUL && (it.a == '0 || it.b == '0))) begin
        iss_q.push_back(it);
        exp_iss++;
      end
    end
    vreq_valid = 1'b1;
    vreq_in_1_signed = s1;
    vreq_in_2_signed = s2;
    vreq_op = op;
    vreq_out_sel = sel;
    vreq_in_1 = a;
    vreq_in_2 = b;
    accept_cyc = cyc + 1;
    @(negedge clk);
    vreq_valid = 1'b0;
    vreq_in_1 = {$urandom, $urandom};
    vreq_in_2 = {$urandom, $urandom};
    vreq_op = 2'($urandom_range(0, 2));
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (sb_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("completion_timeout", 64'(ok), 64'd1);
    if (!ok) sb_q.delete();
    chk("issue_count", 64'(n_issue), 64'(exp_iss));
  endtask

  function automatic logic [XPR-1:0] rand_lane();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [VW-1:0] a, b;
    logic [1:0] op, sel;
    logic s1, s2;
    bit ok;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vreq_ready", vreq_ready, 1'b1);
    chk("rst_vresp_valid", vresp_valid, 1'b0);
    chk("rst_md_req_valid", md_req_valid, 1'b0);
    chk("rst_vresp_result", vresp_result, 64'd0);
    reset = 1'b1;

    send(1, 1, OP_MUL, SEL_LO, {32'hFFFFFFFE, 32'd3}, {32'd7, 32'd5},
         {32'hFFFFFFF2, 32'h0000000F}, 5);
    wait_done();
    send(0, 0, OP_DIV, SEL_LO, {32'd9, 32'd100}, {32'd3, 32'd7}, {32'd3, 32'd14}, 5);
    wait_done();
    stall_cnt = 4;
    send(1, 0, OP_MUL, SEL_LO, {32'd6, 32'd11}, {32'd2, 32'd13}, {32'd12, 32'd143}, 9);
    wait_done();
    hold_cnt = 3;
    send(0, 0, OP_REM, SEL_REM, {32'd20, 32'd17}, {32'd6, 32'd5}, {32'd2, 32'd2}, 5);
    wait_done();

    // Reset during WAIT of lane 1, then a stray scalar response after release.
    a = {32'd12345, 32'd77};
    b = {32'hFFFFFFF0, 32'd3};
    send(1, 1, OP_MUL, SEL_HI, a, b, vec_ref(OP_MUL, SEL_HI, 1, 1, a, b), -1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (n_issue == 2) begin
        ok = 1;
        break;
      end
    end
    chk("reach_lane1_wait", 64'(ok), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_vreq_ready", vreq_ready, 1'b1);
    chk("midrst_vresp_valid", vresp_valid, 1'b0);
    chk("midrst_md_req_valid", md_req_valid, 1'b0);
    chk("midrst_vresp_result", vresp_result, 64'd0);
    sb_q.delete();
    iss_q.delete();
    seen_valid = 0;
    expect_idle = 0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    stray = 1;
    repeat (3) @(negedge clk);
    chk("stray_vreq_ready", vreq_ready, 1'b1);
    chk("stray_vresp_valid", vresp_valid, 1'b0);
    chk("stray_md_req_valid", md_req_valid, 1'b0);
    chk("stray_vresp_result", vresp_result, 64'd0);
    send(0, 1, OP_DIV, SEL_LO, {32'd50, 32'hFFFFFFFF}, {32'hFFFFFFF6, 32'd2},
         vec_ref(OP_DIV, SEL_LO, 0, 1, {32'd50, 32'hFFFFFFFF}, {32'hFFFFFFF6, 32'd2}), 5);
    wait_done();

`ifdef XVEC2_MD_ZERO_SKIP_EN
    send(0, 0, OP_MUL, SEL_LO, {32'd4, 32'd0}, {32'd2, 32'd9}, {32'd8, 32'd0}, 4);
    wait_done();
`endif

    for (int t = 0; t < 40; t++) begin
      a = {rand_lane(), rand_lane()};
      b = {rand_lane(), rand_lane()};
      op = 2'($urandom_range(0, 2));
      sel = (op == OP_MUL) ? 2'($urandom_range(0, 1)) : ((op == OP_DIV) ? SEL_LO : SEL_REM);
      s1 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      stall_cnt = $urandom_range(0, 2);
      hold_cnt = $urandom_range(0, 2);
      send(s1, s2, op, sel, a, b, vec_ref(op, sel, s1, s2, a, b), -1);
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
